uart_txq: RTL and testbench

Parametrised, buffered UART transmitter; the next generation of the design's fixed 8N1 transmitter. Accepts words over a valid/ready handshake into an internal FIFO and serialises them on `tx`. Frame format (data bits, parity, stop bits) is set by parameters; the baud divisor is a run-time input. Sits between a byte source (e.g. the character generator) and the board TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_txq_if.sv | 14 +
 rtl/uart_fifo.sv | 66 ++++++
 rtl/uart_txq.sv | 139 +++++++++++++
 tb/tb_uart_txq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state type, parity mode constants
// and a word-parity helper. Intended for reuse by a future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Even parity of a word of up to 8 bits (callers zero-extend narrower words).
  function automatic logic parity_of(input logic [7:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/uart_txq_if.sv
// Valid/ready word stream into the UART transmitter queue.
//   data  : word to transmit (DATA_BITS wide)
//   valid : data is valid, held until accepted
//   ready : receiver can accept a word this cycle
interface uart_txq_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous single-clock FIFO with first-word-fall-through read port.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   i_push   : write i_data (ignored when full)
//   i_pop    : discard head word (ignored when empty)
//   o_data   : head word, valid while !o_empty
//   o_full / o_empty / o_level : registered occupancy status
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [LW-1:0]    r_level, w_level_nxt;
  logic             r_full, r_empty;
  logic             w_wr_en, w_rd_en;

  assign w_wr_en = i_push && !r_full;
  assign w_rd_en = i_pop && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_en && !w_rd_en)
      w_level_nxt = r_level + LW'(1);
    else if (!w_wr_en && w_rd_en)
      w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr_en) r_wr <= r_wr + AW'(1);
      if (w_rd_en) r_rd <= r_rd + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/uart_txq.sv
// Buffered, parametrised UART transmitter. Words enter a FIFO over a
// valid/ready stream and are serialised LSB first as
// start / DATA_BITS data / optional parity / STOP_BITS stop.
//   clk, rst : clock, synchronous active-high reset
//   div      : clocks per bit (values below 2 act as 2), sampled at frame start
//   s_in     : input word stream (slave side)
//   tx       : serial line, idle high
//   busy     : a frame is in progress
//   level    : words waiting in the FIFO (excluding the one being shifted)
module uart_txq
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIV_W-1:0]       div,
  uart_txq_if.slave              s_in,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  uart_tx_state_t       r_state, w_state_nxt;
  logic [DIV_W-1:0]     r_cnt, r_div_m1, w_div_eff;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt, w_fifo_data;
  logic                 r_par, r_tx, r_busy;
  logic                 w_tx_nxt, w_busy_nxt;
  logic                 w_tick, w_pop, w_push, w_full, w_empty;

  assign s_in.ready = !w_full && !rst;
  assign w_push     = s_in.valid && s_in.ready;
  assign w_div_eff  = (div < DIV_W'(2)) ? DIV_W'(2) : div;
  assign w_tick     = (r_cnt == '0);

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (s_in.data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Next state, FIFO pop and shift-register update.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: if (w_tick) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_tick && r_bit == 3'(DATA_BITS - 1))
          w_state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      end
      ST_PAR: if (w_tick) w_state_nxt = ST_STOP;
      ST_STOP: begin
        // Last stop period: chain straight into the next frame if one is queued.
        if (w_tick && r_bit == 3'(STOP_BITS - 1)) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_shift_nxt = r_shift;
    if (w_pop)
      w_shift_nxt = w_fifo_data;
    else if (r_state == ST_DATA && w_tick)
      w_shift_nxt = r_shift >> 1;
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
      ST_PAR:   w_tx_nxt = r_par;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_div_m1 <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      if (w_pop) begin
        r_div_m1 <= w_div_eff - DIV_W'(1);
        r_cnt    <= w_div_eff - DIV_W'(1);
        r_bit    <= '0;
        r_par    <= parity_of(8'(w_fifo_data)) ^ (PARITY == PAR_ODD);
      end else if (r_state != ST_IDLE) begin
        if (w_tick) begin
          r_cnt <= r_div_m1;
          // Bit counter serves both DATA and multi-period STOP; cleared on state change.
          r_bit <= (w_state_nxt == r_state) ? r_bit + 3'd1 : '0;
        end else begin
          r_cnt <= r_cnt - DIV_W'(1);
        end
      end
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_txq.sv
module tb_uart_txq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] dv  [3];
  logic [7:0]  dat [3];
  logic        vld [3];

  uart_txq_if #(.DATA_BITS(8)) if0 ();
  uart_txq_if #(.DATA_BITS(7)) if1 ();
  uart_txq_if #(.DATA_BITS(8)) if2 ();

  assign if0.data  = dat[0];
  assign if0.valid = vld[0];
  assign if1.data  = dat[1][6:0];
  assign if1.valid = vld[1];
  assign if2.data  = dat[2];
  assign if2.valid = vld[2];

  logic       tx0, tx1, tx2, bz0, bz1, bz2;
  logic [2:0] lv0;
  logic [3:0] lv1;
  logic [2:0] lv2;

  uart_txq #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4), .DIV_W(16)) u0 (
    .clk(clk), .rst(rst), .div(dv[0]), .s_in(if0), .tx(tx0), .busy(bz0), .level(lv0));
  uart_txq #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DEPTH(8), .DIV_W(16)) u1 (
    .clk(clk), .rst(rst), .div(dv[1]), .s_in(if1), .tx(tx1), .busy(bz1), .level(lv1));
  uart_txq #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4), .DIV_W(16)) u2 (
    .clk(clk), .rst(rst), .div(dv[2]), .s_in(if2), .tx(tx2), .busy(bz2), .level(lv2));

  logic       o_tx  [3];
  logic       o_bz  [3];
  logic       o_rdy [3];
  logic [3:0] o_lv  [3];
  assign o_tx[0] = tx0;  assign o_tx[1] = tx1;  assign o_tx[2] = tx2;
  assign o_bz[0] = bz0;  assign o_bz[1] = bz1;  assign o_bz[2] = bz2;
  assign o_rdy[0] = if0.ready; assign o_rdy[1] = if1.ready; assign o_rdy[2] = if2.ready;
  assign o_lv[0] = {1'b0, lv0}; assign o_lv[1] = lv1; assign o_lv[2] = {1'b0, lv2};

  int unsigned cfg_nb  [3] = '{8, 7, 8};
  int unsigned cfg_par [3] = '{0, 2, 1};
  int unsigned cfg_sb  [3] = '{1, 2, 1};
  int unsigned cfg_dp  [3] = '{4, 8, 4};

  // Reference model: queued words, and the expected line level for every
  // remaining cycle of the frame currently on the wire.
  int unsigned mq [3][$];
  bit          cq [3][$];

  int unsigned ntests = 0;
  int unsigned nfail  = 0;
  int unsigned cyc    = 0;
  bit          took [3];
  bit          pbz  [3];
  int unsigned bcnt [3];
  int unsigned bfall[3];
  int unsigned lmax [3];
  bit          wtx  [3][64];
  bit          wbz  [3][64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic load_frame(input int k, input int unsigned w, input int unsigned d);
    bit          bits[$];
    int unsigned ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int unsigned i = 0; i < cfg_nb[k]; i++) begin
      bits.push_back(w[i]);
      ones += w[i];
    end
    if (cfg_par[k] == 1) bits.push_back(bit'(ones % 2 == 1));
    if (cfg_par[k] == 2) bits.push_back(bit'(ones % 2 == 0));
    for (int unsigned i = 0; i < cfg_sb[k]; i++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int unsigned j = 0; j < d; j++) cq[k].push_back(bits[i]);
  endtask

  task automatic model_step();
    bit          rdy;
    int unsigned d;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mq[k].delete();
        cq[k].delete();
      end else begin
        rdy = (mq[k].size() < cfg_dp[k]);
        if (cq[k].size() != 0) void'(cq[k].pop_front());
        if (cq[k].size() == 0 && mq[k].size() != 0) begin
          d = (dv[k] < 16'd2) ? 2 : int'(dv[k]);
          load_frame(k, mq[k].pop_front(), d);
        end
        if (vld[k] && rdy)
          mq[k].push_back(int'(dat[k]) & ((32'd1 << cfg_nb[k]) - 1));
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tx%0d", k), 32'(o_tx[k]), (cq[k].size() != 0) ? 32'(cq[k][0]) : 32'd1);
      chk($sformatf("busy%0d", k), 32'(o_bz[k]), 32'(cq[k].size() != 0));
      chk($sformatf("level%0d", k), 32'(o_lv[k]), 32'(mq[k].size()));
      chk($sformatf("ready%0d", k), 32'(o_rdy[k]), 32'(!rst && mq[k].size() < cfg_dp[k]));
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) took[k] = vld[k] && o_rdy[k];
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (o_bz[k]) bcnt[k]++;
      if (pbz[k] && !o_bz[k]) bfall[k]++;
      pbz[k] = o_bz[k];
      if (32'(o_lv[k]) > lmax[k]) lmax[k] = 32'(o_lv[k]);
    end
    check_all();
  endtask

  task automatic push(input int k, input int unsigned w);
    bit acc;
    acc = 1'b0;
    dat[k] = 8'(w);
    vld[k] = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      tick();
      acc = took[k];
    end
    vld[k] = 1'b0;
    chk($sformatf("push%0d_accept", k), 32'(acc), 32'd1);
  endtask

  task automatic wait_idle(input int k, input int unsigned bound);
    int unsigned i;
    i = 0;
    while ((o_bz[k] || o_lv[k] != 0) && i < bound) begin
      tick();
      i++;
    end
    chk($sformatf("idle%0d_reached", k), 32'(o_bz[k] || o_lv[k] != 0), 32'd0);
  endtask

  task automatic clr_stats();
    for (int k = 0; k < 3; k++) begin
      bcnt[k] = 0; bfall[k] = 0; lmax[k] = 0;
    end
  endtask

  initial begin
    int unsigned v55;
    int unsigned exp1[11] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    int unsigned e;
    int unsigned nb;

    rst = 1'b1;
    vld = '{1'b0, 1'b0, 1'b0};
    dat = '{8'h00, 8'h00, 8'h00};
    dv  = '{16'd4, 16'd3, 16'd2};
    clr_stats();

    // Reset state
    repeat (3) tick();
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_busy", 32'(bz0), 32'd0);
    chk("rst_level", 32'(lv0), 32'd0);
    chk("rst_ready", 32'(if0.ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(if0.ready), 32'd1);

    // Basic 8N1 / 7O2 / 8E1 frames captured together
    dat = '{8'h55, 8'h03, 8'hFF};
    vld = '{1'b1, 1'b1, 1'b1};
    tick();
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    dat[2] = 8'h7F;
    for (int i = 1; i < 64; i++) begin
      if (i == 2) vld[2] = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
        wtx[k][i] = o_tx[k];
        wbz[k][i] = o_bz[k];
      end
    end
    for (int k = 0; k < 3; k++) begin
      nb = 0;
      for (int i = 1; i < 64; i++) nb += 32'(wbz[k][i]);
      chk($sformatf("frame_len%0d", k), nb, (k == 0) ? 40 : (k == 1) ? 33 : 44);
      chk($sformatf("start_edge%0d", k), 32'(wtx[k][1]), 32'd0);
      chk($sformatf("busy_rise%0d", k), 32'(wbz[k][1]), 32'd1);
    end
    chk("busy_fall0", 32'(wbz[0][41]), 32'd0);
    v55 = 32'h55;
    for (int b = 0; b < 10; b++) begin
      e = (b == 0) ? 0 : (b == 9) ? 1 : 32'(v55[b-1]);
      chk($sformatf("b8n1_bit%0d", b), 32'(wtx[0][2 + 4*b]), e);
    end
    for (int b = 0; b < 11; b++)
      chk($sformatf("b7o2_bit%0d", b), 32'(wtx[1][2 + 3*b]), exp1[b]);
    chk("even_par_ff", 32'(wtx[2][19]), 32'd0);
    chk("b2b_start2", 32'(wtx[2][23]), 32'd0);
    chk("even_par_7f", 32'(wtx[2][41]), 32'd1);

    // Full FIFO and back-to-back frames
    dv[0] = 16'd2;
    clr_stats();
    for (int w = 1; w <= 6; w++) push(0, w);
    wait_idle(0, 400);
    chk("b2b_busy_cycles", bcnt[0], 32'd120);
    chk("b2b_single_burst", bfall[0], 32'd1);
    chk("b2b_level_max", lmax[0], 32'd4);

    // Divisor change mid-frame, then clamping of div=0
    dv[0] = 16'd4;
    clr_stats();
    push(0, 32'hA5);
    repeat (6) tick();
    dv[0] = 16'd8;
    push(0, 32'h3C);
    wait_idle(0, 400);
    chk("divchg_busy_cycles", bcnt[0], 32'd120);
    chk("divchg_single_burst", bfall[0], 32'd1);
    dv[0] = 16'd0;
    clr_stats();
    push(0, 32'h81);
    wait_idle(0, 400);
    chk("div0_busy_cycles", bcnt[0], 32'd20);

    // Reset during DATA with words queued
    dv[0] = 16'd4;
    push(0, 32'h11);
    push(0, 32'h22);
    push(0, 32'h33);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tx", 32'(tx0), 32'd1);
    chk("midrst_busy", 32'(bz0), 32'd0);
    chk("midrst_level", 32'(lv0), 32'd0);
    clr_stats();
    repeat (60) tick();
    chk("midrst_no_frames", bcnt[0], 32'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (took[k]) vld[k] = 1'b0;
        if (!vld[k] && $urandom_range(0, 3) == 0) begin
          dat[k] = 8'($urandom);
          vld[k] = 1'b1;
        end
        if ($urandom_range(0, 99) == 0) dv[k] = 16'($urandom_range(0, 5));
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    vld = '{1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) wait_idle(k, 1000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
